// File: rtl/bless_port_alloc.sv
// bless_port_alloc -- switch allocator for a bufferless deflection (BLESS) router.
//
// Purpose:
//   Gives every valid incoming link flit an output port for the next cycle.
//   Flits are served oldest first. The flit that wins is ejected to the
//   local sink when it is destined here. Flits that lose are deflected to a
//   free port. One local injection goes into a slot that is left free.
//   All link and ejection outputs are registered, so the latency is 1 cycle.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   ctrl_in_n/s/e/w          incoming control words {valid, src[3:0], dest[3:0], age[3:0]}
//   rmatrix_n/s/e/w          productive directions per input {W, E, S, N}
//   resource_go[3:0]         per input (n,s,e,w): flit is destined for this router
//   eject_ready              the local sink can accept one flit this cycle
//   inj_req, inj_ctrl,       local injection request, its control word and
//   inj_rmatrix              its productive directions
//   inj_ack                  combinational: the injected flit is taken at this edge
//   ctrl_out_n/s/e/w         registered outgoing control words (all zero = idle)
//   eject_valid, eject_ctrl  registered ejected flit
//   starve                   registered injection-starvation flag
//
// Configuration:
//   BLESS_STARVE_EN  defined: counts consecutive blocked injection cycles and
//                    raises starve once the count reaches STARVE_LIMIT.
//                    undefined: starve is tied low.

`ifndef CONTROL_W
`define CONTROL_W 13
`endif
`ifndef RMATRIX_W
`define RMATRIX_W 4
`endif

module bless_port_alloc #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [`CONTROL_W-1:0] ctrl_in_n,
  input  logic [`CONTROL_W-1:0] ctrl_in_s,
  input  logic [`CONTROL_W-1:0] ctrl_in_e,
  input  logic [`CONTROL_W-1:0] ctrl_in_w,
  input  logic [`RMATRIX_W-1:0] rmatrix_n,
  input  logic [`RMATRIX_W-1:0] rmatrix_s,
  input  logic [`RMATRIX_W-1:0] rmatrix_e,
  input  logic [`RMATRIX_W-1:0] rmatrix_w,
  input  logic [3:0]            resource_go,
  input  logic                  eject_ready,
  input  logic                  inj_req,
  input  logic [`CONTROL_W-1:0] inj_ctrl,
  input  logic [`RMATRIX_W-1:0] inj_rmatrix,
  output logic                  inj_ack,
  output logic [`CONTROL_W-1:0] ctrl_out_n,
  output logic [`CONTROL_W-1:0] ctrl_out_s,
  output logic [`CONTROL_W-1:0] ctrl_out_e,
  output logic [`CONTROL_W-1:0] ctrl_out_w,
  output logic                  eject_valid,
  output logic [`CONTROL_W-1:0] eject_ctrl,
  output logic                  starve
);

  localparam int CW = `CONTROL_W;
  localparam int RW = `RMATRIX_W;

  logic [CW-1:0] cin   [4];
  logic [RW-1:0] rin   [4];
  logic [3:0]    valid;
  logic [3:0]    age   [4];
  logic [1:0]    rot   [4];  // distance of each input from rr_ptr
  logic [1:0]    rank  [4];  // position in the priority order among valid inputs
  logic [1:0]    rr_ptr;
  logic          tie_at_top;

  logic [CW-1:0] out_nxt [4];
  logic          ej_hit;
  logic [CW-1:0] ej_nxt;
  logic [3:0]    free;
  logic [3:0]    grant;

  assign cin[0] = ctrl_in_n;
  assign cin[1] = ctrl_in_s;
  assign cin[2] = ctrl_in_e;
  assign cin[3] = ctrl_in_w;
  assign rin[0] = rmatrix_n;
  assign rin[1] = rmatrix_s;
  assign rin[2] = rmatrix_e;
  assign rin[3] = rmatrix_w;

  // The flit leaves with its age plus one. The age saturates at 4'hF.
  // The forwarded word is always valid.
  function automatic logic [CW-1:0] fwd(input logic [CW-1:0] w);
    logic [3:0] a;
    a = (w[3:0] == 4'hF) ? 4'hF : w[3:0] + 4'd1;
    return {1'b1, w[11:4], a};
  endfunction

  // Choose the lowest free productive port. If none is free, choose the
  // lowest free port. The result is one-hot, or zero when nothing is free.
  function automatic logic [3:0] pick_port(input logic [3:0] prod, input logic [3:0] fr);
    logic [3:0] cand;
    cand = ((prod & fr) != 4'b0) ? (prod & fr) : fr;
    return cand & (~cand + 4'd1);  // keep only the lowest set bit
  endfunction

  // Rank every valid input. Input i loses to input j when j is older. When
  // both have the same age, i loses when j is closer to rr_ptr in n,s,e,w order.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      valid[i] = cin[i][12];
      age[i]   = cin[i][3:0];
      rot[i]   = 2'(i) - rr_ptr;
    end
    for (int i = 0; i < 4; i++) begin
      rank[i] = 2'd0;
      for (int j = 0; j < 4; j++) begin
        if (j != i && valid[j] &&
            ((age[j] > age[i]) || (age[j] == age[i] && rot[j] < rot[i])))
          rank[i] = rank[i] + 2'd1;
      end
    end
  end

  // rr_ptr advances only when the oldest age is shared by two or more inputs.
  always_comb begin
    logic [2:0] top_cnt;
    logic       is_top;
    top_cnt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      is_top = valid[i];
      for (int j = 0; j < 4; j++)
        if (valid[j] && age[j] > age[i]) is_top = 1'b0;
      if (is_top) top_cnt = top_cnt + 3'd1;
    end
    tie_at_top = (top_cnt >= 3'd2);
  end

  // Visit the inputs in priority order. Each one either takes the single
  // ejection slot or claims a port from the free mask.
  // NOTE: every variable written here gets its default value before any
  // branch, so this block cannot infer a latch. Blocking '=' is used on
  // purpose: each later iteration must see the free mask that earlier
  // iterations updated.
  always_comb begin
    out_nxt = '{default: '0};
    free    = 4'hF;
    grant   = 4'b0;
    ej_hit  = 1'b0;
    ej_nxt  = '0;
    inj_ack = 1'b0;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 4; i++) begin
        if (valid[i] && rank[i] == 2'(p)) begin
          if (eject_ready && resource_go[i] && !ej_hit) begin
            ej_hit = 1'b1;
            ej_nxt = cin[i];
          end else begin
            // A flit that is destined here but not ejected has no productive port.
            grant = pick_port(resource_go[i] ? 4'b0 : rin[i], free);
            free  = free & ~grant;
            for (int q = 0; q < 4; q++)
              if (grant[q]) out_nxt[q] = fwd(cin[i]);
          end
        end
      end
    end
    // Every non-ejected flit holds one port, so a free port remains exactly
    // when fewer than four flits are forwarded.
    inj_ack = inj_req && (free != 4'b0);
    if (inj_ack) begin
      grant = pick_port(inj_rmatrix, free);
      free  = free & ~grant;
      for (int q = 0; q < 4; q++)
        if (grant[q]) out_nxt[q] = fwd(inj_ctrl);
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so that every register
  // samples values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_out_n  <= '0;
      ctrl_out_s  <= '0;
      ctrl_out_e  <= '0;
      ctrl_out_w  <= '0;
      eject_valid <= 1'b0;
      eject_ctrl  <= '0;
      rr_ptr      <= 2'd0;
    end else begin
      ctrl_out_n  <= out_nxt[0];
      ctrl_out_s  <= out_nxt[1];
      ctrl_out_e  <= out_nxt[2];
      ctrl_out_w  <= out_nxt[3];
      eject_valid <= ej_hit;
      eject_ctrl  <= ej_nxt;
      if (tie_at_top) rr_ptr <= rr_ptr + 2'd1;
    end
  end

`ifdef BLESS_STARVE_EN
  localparam int SCW = $clog2(STARVE_LIMIT + 1);
  logic [SCW-1:0] starve_cnt;
  logic [SCW-1:0] starve_cnt_nxt;

  always_comb begin
    starve_cnt_nxt = '0;
    if (inj_req && !inj_ack)
      starve_cnt_nxt = (starve_cnt >= SCW'(STARVE_LIMIT)) ? SCW'(STARVE_LIMIT)
                                                          : starve_cnt + SCW'(1);
  end

  // starve follows the next count value, so it rises on the same edge that
  // the count reaches the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      starve     <= 1'b0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
      starve     <= (starve_cnt_nxt >= SCW'(STARVE_LIMIT));
    end
  end
`else
  // STARVE_LIMIT is only used when the starvation counter is built.
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign starve = 1'b0;
`endif

endmodule

// File: tb/tb_bless_port_alloc.sv
// tb_bless_port_alloc -- self-checking bench for bless_port_alloc.
// It runs directed scenarios with literal expectations, then randomized traffic.
// Every cycle is compared against a reference model in the bench. The model
// sorts the flits by priority, ejects, and fills ports from a list.

`ifndef CONTROL_W
`define CONTROL_W 13
`endif
`ifndef RMATRIX_W
`define RMATRIX_W 4
`endif

module tb_bless_port_alloc;

  localparam int STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] cin [4];
  logic [3:0]  rm  [4];
  logic [3:0]  rgo;
  logic        ej_rdy;
  logic        inj_req;
  logic [12:0] inj_ctrl;
  logic [3:0]  inj_rm;
  logic        inj_ack;
  logic [12:0] cout [4];
  logic        ej_valid;
  logic [12:0] ej_ctrl;
  logic        starve;

  int checks = 0;
  int errors = 0;

  // Model state: the registered outputs expected now, and the values for the next edge.
  int          m_rr, m_cnt, n_rr, n_cnt;
  logic [12:0] e_out [4];
  logic [12:0] n_out [4];
  logic        e_ejv, n_ejv, e_starve, n_starve, n_ack;
  logic [12:0] e_ej, n_ej;
  logic [3:0]  m_free;

  bless_port_alloc #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .ctrl_in_n(cin[0]), .ctrl_in_s(cin[1]), .ctrl_in_e(cin[2]), .ctrl_in_w(cin[3]),
    .rmatrix_n(rm[0]), .rmatrix_s(rm[1]), .rmatrix_e(rm[2]), .rmatrix_w(rm[3]),
    .resource_go(rgo), .eject_ready(ej_rdy),
    .inj_req(inj_req), .inj_ctrl(inj_ctrl), .inj_rmatrix(inj_rm), .inj_ack(inj_ack),
    .ctrl_out_n(cout[0]), .ctrl_out_s(cout[1]), .ctrl_out_e(cout[2]), .ctrl_out_w(cout[3]),
    .eject_valid(ej_valid), .eject_ctrl(ej_ctrl), .starve(starve)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [12:0] fwd(input logic [12:0] w);
    int a;
    a = int'(w[3:0]);
    a = (a < 15) ? a + 1 : 15;
    return {1'b1, w[11:4], 4'(a)};
  endfunction

  task automatic place(input logic [12:0] w, input logic [3:0] prod);
    int port;
    port = -1;
    for (int p = 0; p < 4; p++) if (port < 0 && prod[p] && m_free[p]) port = p;
    for (int p = 0; p < 4; p++) if (port < 0 && m_free[p]) port = p;
    if (port >= 0) begin
      n_out[port]  = fwd(w);
      m_free[port] = 1'b0;
    end
  endtask

  // Reference model: build the priority list, then eject, route and inject.
  task automatic model_eval();
    int ord[$];
    int key[4];
    bit used[4];
    int best, maxa, nmax, ej, nv;
    ord = {};
    for (int i = 0; i < 4; i++) begin
      used[i] = 0;
      key[i]  = int'(cin[i][3:0]) * 4 + (3 - ((i - m_rr + 4) % 4));
    end
    for (int n = 0; n < 4; n++) begin
      best = -1;
      for (int i = 0; i < 4; i++)
        if (cin[i][12] && !used[i] && (best < 0 || key[i] > key[best])) best = i;
      if (best >= 0) begin ord.push_back(best); used[best] = 1; end
    end
    maxa = -1;
    foreach (ord[k]) if (int'(cin[ord[k]][3:0]) > maxa) maxa = int'(cin[ord[k]][3:0]);
    nmax = 0;
    foreach (ord[k]) if (int'(cin[ord[k]][3:0]) == maxa) nmax++;
    n_rr = (nmax >= 2) ? (m_rr + 1) % 4 : m_rr;

    ej = -1;
    if (ej_rdy) foreach (ord[k]) if (ej < 0 && rgo[ord[k]]) ej = ord[k];

    for (int q = 0; q < 4; q++) n_out[q] = '0;
    m_free = 4'hF;
    foreach (ord[k])
      if (ord[k] != ej) place(cin[ord[k]], rgo[ord[k]] ? 4'b0 : rm[ord[k]]);
    nv = ord.size() - ((ej >= 0) ? 1 : 0);
    n_ack = inj_req && (nv < 4);
    if (n_ack) place(inj_ctrl, inj_rm);

    n_ejv = (ej >= 0);
    n_ej  = (ej >= 0) ? cin[ej] : 13'h0;
`ifdef BLESS_STARVE_EN
    n_cnt    = (inj_req && !n_ack) ? ((m_cnt + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_cnt + 1) : 0;
    n_starve = (n_cnt >= STARVE_LIMIT);
`else
    n_cnt    = 0;
    n_starve = 1'b0;
`endif
  endtask

  task automatic model_reset();
    m_rr = 0; m_cnt = 0;
    for (int q = 0; q < 4; q++) e_out[q] = '0;
    e_ejv = 0; e_ej = '0; e_starve = 0;
  endtask

  // Drive inputs at the negedge first, then call this. It checks inj_ack
  // before the edge and the registered outputs at the next negedge.
  task automatic step();
    #1;
    model_eval();
    check("inj_ack", 32'(inj_ack), 32'(n_ack));
    @(posedge clk);
    for (int q = 0; q < 4; q++) e_out[q] = n_out[q];
    e_ejv = n_ejv; e_ej = n_ej; e_starve = n_starve;
    m_rr = n_rr; m_cnt = n_cnt;
    @(negedge clk);
    for (int q = 0; q < 4; q++)
      check($sformatf("ctrl_out[%0d]", q), 32'(cout[q]), 32'(e_out[q]));
    check("eject_valid", 32'(ej_valid), 32'(e_ejv));
    check("eject_ctrl", 32'(ej_ctrl), 32'(e_ej));
    check("starve", 32'(starve), 32'(e_starve));
  endtask

  task automatic clear_in();
    for (int i = 0; i < 4; i++) begin cin[i] = '0; rm[i] = '0; end
    rgo = '0; ej_rdy = 0; inj_req = 0; inj_ctrl = '0; inj_rm = '0;
  endtask

  task automatic four_busy();
    clear_in();
    cin[0] = 13'h1104; rm[0] = 4'b0001;
    cin[1] = 13'h1203; rm[1] = 4'b0010;
    cin[2] = 13'h1302; rm[2] = 4'b0100;
    cin[3] = 13'h1401; rm[3] = 4'b1000;
    inj_req = 1; inj_ctrl = 13'h1890; inj_rm = 4'b0010;
  endtask

  task automatic tie_ew();
    clear_in();
    cin[2] = 13'h1407; rm[2] = 4'b0001;
    cin[3] = 13'h1507; rm[3] = 4'b0001;
  endtask

  function automatic logic [3:0] rand_age();
    int r;
    r = $urandom_range(0, 3);
    if (r == 0) return 4'hF;
    if (r == 1) return 4'h7;
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    rst = 1;
    clear_in();
    model_reset();
    @(negedge clk);
    for (int q = 0; q < 4; q++) check("reset ctrl_out", 32'(cout[q]), 32'h0);
    check("reset eject_valid", 32'(ej_valid), 32'h0);
    check("reset eject_ctrl", 32'(ej_ctrl), 32'h0);
    check("reset starve", 32'(starve), 32'h0);
    rst = 0;

    // A single flit goes to its productive port with age+1.
    cin[0] = 13'h1123; rm[0] = 4'b0100;
    step();
    check("single out_e", 32'(cout[2]), 32'h1124);
    check("single out_n", 32'(cout[0]), 32'h0);

    // The older flit wins E. The younger flit is deflected to N.
    clear_in();
    cin[0] = 13'h1259; rm[0] = 4'b0100;
    cin[1] = 13'h1355; rm[1] = 4'b0100;
    step();
    check("age out_e", 32'(cout[2]), 32'h125A);
    check("age out_n", 32'(cout[0]), 32'h1356);

    // Equal ages: e wins N while rr_ptr is 0..2. w wins N once rr_ptr is 3.
    for (int k = 0; k < 4; k++) begin
      tie_ew();
      step();
      check("tie out_n", 32'(cout[0]), (k < 3) ? 32'h1408 : 32'h1508);
      check("tie out_s", 32'(cout[1]), (k < 3) ? 32'h1508 : 32'h1408);
    end

    // Ejection picks the oldest flit that is destined here. The other is deflected.
    clear_in();
    cin[1] = 13'h1632; cin[3] = 13'h1738; rgo = 4'b1010; ej_rdy = 1;
    step();
    check("eject ctrl", 32'(ej_ctrl), 32'h1738);
    check("eject valid", 32'(ej_valid), 32'h1);
    check("eject defl n", 32'(cout[0]), 32'h1633);
    ej_rdy = 0;
    step();
    check("noeject valid", 32'(ej_valid), 32'h0);
    check("noeject n", 32'(cout[0]), 32'h1739);
    check("noeject s", 32'(cout[1]), 32'h1633);

    // Injection is blocked when all four ports are busy. It is accepted when one port is free.
    four_busy();
    #1 check("inj blocked", 32'(inj_ack), 32'h0);
    step();
    four_busy(); cin[0] = 13'h1105; cin[1] = 13'h1204; cin[2] = 13'h1303;
    cin[3] = '0;
    #1 check("inj accepted", 32'(inj_ack), 32'h1);
    step();
    check("inj out_w", 32'(cout[3]), 32'h1891);

    // Starvation: STARVE_LIMIT blocked cycles, then one accepted injection.
    for (int k = 1; k <= STARVE_LIMIT; k++) begin
      four_busy();
      step();
`ifdef BLESS_STARVE_EN
      check("starve rise", 32'(starve), (k == STARVE_LIMIT) ? 32'h1 : 32'h0);
`else
      check("starve off", 32'(starve), 32'h0);
`endif
    end
    four_busy(); cin[3] = '0;
    step();
    check("starve clear", 32'(starve), 32'h0);

    // Move rr_ptr to 3, then reset in the middle of a cycle.
    for (int k = 0; k < 3; k++) begin tie_ew(); step(); end
    tie_ew();
    #2 rst = 1;
    #1;
    for (int q = 0; q < 4; q++) check("midrst ctrl_out", 32'(cout[q]), 32'h0);
    check("midrst eject_valid", 32'(ej_valid), 32'h0);
    check("midrst starve", 32'(starve), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 0;
    tie_ew();
    step();
    check("postrst rr tie", 32'(cout[0]), 32'h1408);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      int busy;
      busy = (c % 200) < 40;
      for (int i = 0; i < 4; i++) begin
        cin[i] = {1'($urandom_range(0, 99) < (busy ? 100 : 70)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), rand_age()};
        rgo[i] = !busy && ($urandom_range(0, 3) == 0);
        rm[i]  = rgo[i] ? 4'b0 : 4'($urandom_range(1, 15));
      end
      ej_rdy   = ($urandom_range(0, 3) != 0);
      inj_req  = ($urandom_range(0, 4) < 3);
      inj_ctrl = {1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), rand_age()};
      inj_rm   = 4'($urandom_range(1, 15));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bless_port_alloc.md
Name: bless_port_alloc

Overview:
- Per-router switch allocator for the bufferless deflection (BLESS) router.
- Takes the four incoming link flits (N/S/E/W) and their route-compute results (rmatrix, resource_go).
- Assigns every valid flit an output port or the ejection port, oldest-first; deflects losers; merges one local injection into a free slot.
- Drives the registered output link control words; sits between route compute and the output link registers.

Parameters:
STARVE_LIMIT, 8, consecutive blocked-injection cycles before starve asserts (only with BLESS_STARVE_EN)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
ctrl_in_n/s/e/w  in  `control_w each  incoming flit control: [12] valid, [11:8] src, [7:4] dest, [3:0] age
rmatrix_n/s/e/w  in  `rmatrix_w each  productive dirs per input: bit3 W, bit2 E, bit1 S, bit0 N; 0 means at destination
resource_go  in  4  per-input "destined here" flag, bit0..3 = n,s,e,w
eject_ready  in  1  local sink can accept one flit this cycle
inj_req  in  1  local resource has a flit to inject
inj_ctrl  in  `control_w  injected flit control word
inj_rmatrix  in  `rmatrix_w  productive dirs for injected flit
inj_ack  out  1  combinational; injected flit consumed at this rising edge
ctrl_out_n/s/e/w  out  `control_w each  registered outgoing flit control
eject_valid  out  1  registered; eject_ctrl holds an ejected flit
eject_ctrl  out  `control_w  registered ejected flit
starve  out  1  registered injection-starvation flag

Behaviour:
- Reset (async): ctrl_out_* = 0, eject_valid = 0, eject_ctrl = 0, rr_ptr = 0, starve = 0, starve counter = 0. Reset mid-operation discards in-flight allocation; first post-reset edge behaves as fresh.
- Latency: 1 cycle. Inputs sampled at edge k appear on ctrl_out_*/eject_* after edge k.
- Priority order: valid inputs sorted by age, larger first. Equal ages resolved by index order starting at rr_ptr (0=n,1=s,2=e,3=w), wrapping modulo 4. The injected flit is always last.
- rr_ptr: 2-bit. Increments by 1 (wraps 3->0) on each cycle where at least two valid inputs share the maximum tied age group.
- Ejection: highest-priority valid input with resource_go=1 is ejected when eject_ready=1. It consumes no output port.
  - At most one ejection per cycle.
  - Other resource_go flits, or all of them when eject_ready=0, have rmatrix 0 and are deflected.
- Port allocation, in priority order:
  - Take the lowest-index free productive port set in rmatrix, order N,S,E,W.
  - Otherwise take the lowest-index free port in order N,S,E,W (deflection).
  - Every valid non-ejected flit always gets a port: 4 inputs, 4 outputs.
- Injection: inj_ack = inj_req and (valid non-ejected input count < 4). The injected flit is allocated last by the same rule using inj_rmatrix. The injected flit is never ejected.
- Age: every forwarded flit, including injected, leaves with age+1, saturating at 4'hF. Ejected flits keep their input age.
- Unassigned output ports drive all-zero control words. Invalid inputs are ignored entirely; their rmatrix and resource_go are don't-care.
- eject_valid is high for exactly the cycle after an ejection, otherwise 0.

Optional Feature:
BLESS_STARVE_EN
- Defined: a counter tracks consecutive cycles with inj_req=1 and inj_ack=0.
  - Counter saturates at STARVE_LIMIT.
  - Counter clears on inj_ack=1 or inj_req=0.
  - starve is registered high while counter >= STARVE_LIMIT.
- Undefined: counter absent, starve tied 0, STARVE_LIMIT unused.

Test Plan:
1. Single-flit routing: ctrl_in_n valid, age 3, rmatrix 4'b0100, others invalid -> next cycle ctrl_out_e = same src/dest with age 4; other outputs 0; inj_ack=1 if inj_req.
2. Age priority and deflection: n age 9 and s age 5, both rmatrix 4'b0100 -> ctrl_out_e carries n flit (age 10); ctrl_out_n carries s flit (age 6, deflected).
3. Tie-break: e and w both age 7, rmatrix 4'b0001, rr_ptr=0 -> e wins N, w gets S; rr_ptr becomes 1. Repeat until rr_ptr=3 -> w wins N.
4. Ejection: s (age 2) and w (age 8) both resource_go=1, eject_ready=1 -> eject_ctrl = w flit (age 8), eject_valid=1; s deflected to N. With eject_ready=0 both deflected, eject_valid=0.
5. Injection: all four inputs valid and none ejecting, inj_req=1 -> inj_ack=0. Next cycle only 3 valid -> inj_ack=1, injected flit on its productive port if free, else remaining free port.
6. Starvation (BLESS_STARVE_EN, STARVE_LIMIT=8): 8 blocked cycles -> starve=1 after the 8th edge. inj_ack -> starve=0 next edge. Assert rst mid-run -> all outputs 0 immediately.
